// File: rtl/led_seq_pkg.sv
// LED sequencer shared types and constants.
// State encoding, table field offsets, duty/duration widths.
package led_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  localparam int DUTY_W  = 8;
  localparam int DUR_W   = 4;
  localparam int CFG_W   = 28;

  localparam int B_LSB   = 0;
  localparam int G_LSB   = 8;
  localparam int R_LSB   = 16;
  localparam int DUR_LSB = 24;

endpackage

// File: rtl/led_pwm_ch.sv
// One PWM channel: registered compare of shared counter vs duty.
// Ports: clk, rst_n, i_en, i_duty, i_cnt -> o_pwm.
module led_pwm_ch
  import led_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [DUTY_W-1:0] i_duty,
  input  logic [DUTY_W-1:0] i_cnt,
  output logic              o_pwm
);

  logic r_pwm;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= i_en && (i_cnt < i_duty);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/led_seq_ctrl.sv
// RGB LED pattern sequencer: table of timed colour steps, PWM out.
// Ports: clk, rst_n, start, stop, loop_en, cfg_* -> pwm_*, busy, step_idx, done.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter logic [23:0] PRESCALE = 24'd12000000,
  parameter int          STEPS    = 8,
  localparam int         AW       = $clog2(STEPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             pwm_r,
  output logic             pwm_g,
  output logic             pwm_b,
  output logic             busy,
  output logic [AW-1:0]    step_idx,
  output logic             done
);

  logic [CFG_W-1:0] r_tab [STEPS];

  state_t            r_state;
  state_t            w_state_nx;
  logic [23:0]       r_pre;
  logic [DUR_W-1:0]  r_tick_cnt;
  logic [DUR_W-1:0]  r_dur;
  logic [DUTY_W-1:0] r_duty_r;
  logic [DUTY_W-1:0] r_duty_g;
  logic [DUTY_W-1:0] r_duty_b;
  logic [DUTY_W-1:0] r_pwm_cnt;
  logic [AW-1:0]     r_step;
  logic              r_done;

  logic [CFG_W-1:0]  w_entry;
  logic              w_tick;
  logic              w_step_end;
  logic              w_last;
  logic              w_fin;
  logic              w_en;

  // LUT-RAM style table: sync write, async read.
  // A LOAD reads the old word when written in the same cycle.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      r_tab[cfg_addr] <= cfg_data;
    end
  end

  assign w_entry    = r_tab[r_step];
  assign w_tick     = (r_state == S_RUN) &&
                      (r_pre == PRESCALE - 24'd1);
  assign w_step_end = w_tick && (r_tick_cnt == r_dur);
  assign w_last     = (r_step == AW'(STEPS - 1));
  assign w_en       = (w_state_nx != S_IDLE);

  always_comb begin
    w_state_nx = r_state;
    w_fin      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_nx = S_RUN;
      end
      S_RUN: begin
        if (w_step_end) begin
          if (!w_last || loop_en) begin
            w_state_nx = S_LOAD;
          end else begin
            w_state_nx = S_IDLE;
            w_fin      = 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
    // stop wins over start and over a step end
    if (stop) begin
      w_state_nx = S_IDLE;
      w_fin      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_done     <= 1'b0;
      r_pre      <= '0;
      r_tick_cnt <= '0;
      r_dur      <= '0;
      r_duty_r   <= '0;
      r_duty_g   <= '0;
      r_duty_b   <= '0;
      r_pwm_cnt  <= '0;
      r_step     <= '0;
    end else begin
      r_state <= w_state_nx;
      r_done  <= w_fin;

      if (r_state == S_RUN && w_state_nx == S_RUN) begin
        r_pre <= w_tick ? '0 : r_pre + 24'd1;
      end else begin
        r_pre <= '0;
      end

      if (r_state == S_LOAD || w_state_nx == S_IDLE) begin
        r_tick_cnt <= '0;
      end else if (w_tick) begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end

      if (r_state == S_LOAD) begin
        r_dur <= w_entry[DUR_LSB +: DUR_W];
      end

      if (w_state_nx == S_IDLE) begin
        r_duty_r <= '0;
        r_duty_g <= '0;
        r_duty_b <= '0;
      end else if (r_state == S_LOAD) begin
        r_duty_r <= w_entry[R_LSB +: DUTY_W];
        r_duty_g <= w_entry[G_LSB +: DUTY_W];
        r_duty_b <= w_entry[B_LSB +: DUTY_W];
      end

      if (w_state_nx == S_IDLE) begin
        r_step <= '0;
      end else if (w_step_end) begin
        r_step <= w_last ? '0 : r_step + 1'b1;
      end

      // counts only across consecutive busy cycles
      if (r_state != S_IDLE && w_en) begin
        r_pwm_cnt <= r_pwm_cnt + 1'b1;
      end else begin
        r_pwm_cnt <= '0;
      end
    end
  end

  led_pwm_ch u_ch_r (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_en),
    .i_duty (r_duty_r),
    .i_cnt  (r_pwm_cnt),
    .o_pwm  (pwm_r)
  );

  led_pwm_ch u_ch_g (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_en),
    .i_duty (r_duty_g),
    .i_cnt  (r_pwm_cnt),
    .o_pwm  (pwm_g)
  );

  led_pwm_ch u_ch_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_en),
    .i_duty (r_duty_b),
    .i_cnt  (r_pwm_cnt),
    .o_pwm  (pwm_b)
  );

  assign busy     = (r_state != S_IDLE);
  assign step_idx = r_step;
  assign done     = r_done;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl (PRESCALE=4, STEPS=8).
// Step-timeline reference model plus directed and random scenarios.
module tb_led_seq_ctrl;

  localparam int PRE   = 4;
  localparam int STEPS = 8;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        start    = 1'b0;
  logic        stop     = 1'b0;
  logic        loop_en  = 1'b0;
  logic        cfg_we   = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [27:0] cfg_data = '0;
  logic        pwm_r;
  logic        pwm_g;
  logic        pwm_b;
  logic        busy;
  logic        done;
  logic [2:0]  step_idx;

  always #5 clk = ~clk;

  led_seq_ctrl #(
    .PRESCALE (24'd4),
    .STEPS    (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .pwm_r    (pwm_r),
    .pwm_g    (pwm_g),
    .pwm_b    (pwm_b),
    .busy     (busy),
    .step_idx (step_idx),
    .done     (done)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Reference model: a step is one LOAD cycle (pos 0) followed
  // by (dur+1)*PRE RUN cycles (pos 1..).
  logic [27:0] m_tab [STEPS];
  bit          m_act  = 0;
  int          m_step = 0;
  int          m_pos  = 0;
  int          m_dur  = 0;
  int          m_pc   = 0;
  int          m_duty [3] = '{0, 0, 0};
  bit          m_done = 0;
  bit   [2:0]  m_pwm  = '0;

  task automatic m_idle();
    m_act  = 0;
    m_step = 0;
    m_pos  = 0;
    m_pc   = 0;
    m_pwm  = '0;
    for (int c = 0; c < 3; c++) m_duty[c] = 0;
  endtask

  task automatic model_edge();
    logic [27:0] e;
    m_done = 0;
    if (!rst_n) begin
      m_idle();
      m_dur = 0;
    end else if (stop) begin
      m_idle();
    end else if (!m_act) begin
      if (start) begin
        m_act  = 1;
        m_step = 0;
        m_pos  = 0;
        m_pc   = 0;
      end
      m_pwm = '0;
    end else begin
      for (int c = 0; c < 3; c++)
        m_pwm[c] = (m_pc < m_duty[c]);
      m_pc = (m_pc + 1) % 256;
      if (m_pos == 0) begin
        e = m_tab[m_step];
        m_dur     = int'(e[27:24]);
        m_duty[0] = int'(e[23:16]);
        m_duty[1] = int'(e[15:8]);
        m_duty[2] = int'(e[7:0]);
        m_pos = 1;
      end else if (m_pos == (m_dur + 1) * PRE) begin
        if (m_step < STEPS - 1) begin
          m_step++;
          m_pos = 0;
        end else if (loop_en) begin
          m_step = 0;
          m_pos  = 0;
        end else begin
          m_idle();
          m_done = 1;
        end
      end else begin
        m_pos++;
      end
    end
    if (cfg_we) m_tab[cfg_addr] = cfg_data;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("busy",     busy,     32'(m_act));
    check("step_idx", step_idx, 32'(m_step));
    check("done",     done,     32'(m_done));
    check("pwm_r",    pwm_r,    32'(m_pwm[0]));
    check("pwm_g",    pwm_g,    32'(m_pwm[1]));
    check("pwm_b",    pwm_b,    32'(m_pwm[2]));
  endtask

  task automatic wr(input int a, input logic [27:0] d);
    cfg_we   = 1'b1;
    cfg_addr = 3'(a);
    cfg_data = d;
    cyc();
    cfg_we   = 1'b0;
  endtask

  function automatic logic [27:0] ent(input int dur,
      input int r, input int g, input int b);
    return {4'(dur), 8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_at(input int s, input int p,
                         input int lim);
    int k = 0;
    while (!(m_act && m_step == s && m_pos == p)
           && k < lim) begin
      cyc();
      k++;
    end
    check("wait_tmo", 32'(k < lim), 1);
  endtask

  task automatic run_idle(input int lim, output int n_done);
    int k = 0;
    n_done = 0;
    while (busy && k < lim) begin
      cyc();
      if (done) n_done++;
      k++;
    end
    check("idle_tmo", 32'(k < lim), 1);
  endtask

  initial begin
    int nd;
    int n0;
    int hr, hg, hb;
    int k;

    repeat (3) cyc();
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    cyc();

    // sequence with short random middle steps
    wr(0, ent(1, 8'h80, 0, 8'hFF));
    for (int i = 1; i < 7; i++)
      wr(i, ent($urandom_range(0, 3), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255)));
    wr(2, ent(2, 0, 8'h40, 8'hFF));
    wr(4, ent(3, 8'hFF, 0, 1));
    wr(7, ent(0, $urandom_range(0, 255), 8'h11, 8'h22));

    loop_en = 1'b0;
    pulse_start();
    check("busy_rise", busy, 1);
    n0 = 1;
    k = 0;
    while (step_idx == 0 && busy && k < 50) begin
      cyc();
      if (step_idx == 0 && busy) n0++;
      k++;
    end
    check("step0_len", n0, 9);
    run_idle(2000, nd);
    check("done_cnt", nd, 1);

    // loop mode: 0..7,0,1 then stop, never done
    loop_en = 1'b1;
    pulse_start();
    nd = 0;
    k = 0;
    while (!(m_step == 2 && m_pos == 1) && k < 2000) begin
      cyc();
      if (done) nd++;
      k++;
    end
    check("loop_tmo", 32'(k < 2000), 1);
    check("loop_done", nd, 0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("loop_stop", busy, 0);

    // constant duties: count highs over one pwm period
    for (int i = 0; i < STEPS; i++)
      wr(i, ent(15, 8'h80, 0, 8'hFF));
    pulse_start();
    repeat (20) cyc();
    hr = 0; hg = 0; hb = 0;
    for (int i = 0; i < 256; i++) begin
      cyc();
      hr += int'(pwm_r);
      hg += int'(pwm_g);
      hb += int'(pwm_b);
    end
    check("duty128", hr, 128);
    check("duty0",   hg, 0);
    check("duty255", hb, 255);

    // stop coinciding with a step end
    k = 0;
    while (!(m_pos > 0 && m_pos == (m_dur + 1) * PRE)
           && k < 200) begin
      cyc();
      k++;
    end
    check("end_tmo", 32'(k < 200), 1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("se_busy", busy, 0);
    check("se_pwm", {pwm_r, pwm_g, pwm_b}, 0);
    check("se_done", done, 0);
    cyc();
    check("se_done2", done, 0);

    // write entry 3 during its own LOAD
    for (int i = 0; i < STEPS; i++)
      wr(i, ent(0, 0, 8'h33, 8'h55));
    wr(3, ent(15, 0, 8'h10, 8'h20));
    loop_en = 1'b1;
    pulse_start();
    wait_at(3, 0, 500);
    cfg_we   = 1'b1;
    cfg_addr = 3'd3;
    cfg_data = ent(15, 8'hFF, 8'h10, 8'h20);
    cyc();
    cfg_we = 1'b0;
    hr = 0;
    while (step_idx == 3 && busy) begin
      hr += int'(pwm_r);
      cyc();
    end
    check("e3_old", hr, 0);
    wait_at(3, 2, 2000);
    hr = 0;
    k = 0;
    while (step_idx == 3 && busy && k < 100) begin
      hr += int'(pwm_r);
      cyc();
      k++;
    end
    check("e3_new", 32'(hr > 32), 1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;

    // reset mid-run at step 5, table survives
    loop_en = 1'b0;
    pulse_start();
    wait_at(5, 3, 2000);
    rst_n = 1'b0;
    cyc();
    check("rst_busy2", busy, 0);
    check("rst_step", step_idx, 0);
    check("rst_pwm", {pwm_r, pwm_g, pwm_b, done}, 0);
    rst_n = 1'b1;
    cyc();
    pulse_start();
    check("rst_restart", step_idx, 0);
    run_idle(3000, nd);
    check("rst_done", nd, 1);

    // random traffic
    for (int i = 0; i < STEPS; i++)
      wr(i, ent($urandom_range(0, 2), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255)));
    for (int i = 0; i < 6000; i++) begin
      start   = ($urandom_range(0, 15) == 0);
      stop    = ($urandom_range(0, 199) == 0);
      loop_en = $urandom_range(0, 1) == 1;
      rst_n   = ($urandom_range(0, 1499) != 0);
      cfg_we  = ($urandom_range(0, 24) == 0);
      cfg_addr = 3'($urandom_range(0, 7));
      cfg_data = ent($urandom_range(0, 2),
                     $urandom_range(0, 255),
                     $urandom_range(0, 255),
                     $urandom_range(0, 255));
      cyc();
    end
    start  = 1'b0;
    stop   = 1'b0;
    rst_n  = 1'b1;
    cfg_we = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter PRESCALE, default 24'd12000000, clk cycles per sequencer tick (legal range 2..2^24-1).
REQ-002 Parameter STEPS, default 8, number of pattern-table entries (power of 2, 2..16).
REQ-003 clk  input  1  single system clock, all logic on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  level-sampled request to begin the sequence at step 0.
REQ-006 stop  input  1  request to abort the sequence and blank the outputs.
REQ-007 loop_en  input  1  when 1, the sequence wraps after the last step instead of finishing.
REQ-008 cfg_we  input  1  table write strobe.
REQ-009 cfg_addr  input  $clog2(STEPS)  table entry index.
REQ-010 cfg_data  input  28  entry {dur[27:24], r[23:16], g[15:8], b[7:0]}.
REQ-011 pwm_r, pwm_g, pwm_b  output  1 each  PWM drive for the RGB driver's RGB0PWM/RGB1PWM/RGB2PWM inputs.
REQ-012 busy  output  1  high in the LOAD and RUN states.
REQ-013 step_idx  output  $clog2(STEPS)  index of the active step.
REQ-014 done  output  1  one-cycle pulse at normal sequence completion.

Function
REQ-015 States: IDLE, LOAD, RUN. IDLE->LOAD on start=1 && stop=0; LOAD->RUN unconditionally after 1 cycle; RUN->LOAD at step end; any state->IDLE on stop=1.
REQ-016 Prescaler: 24-bit counter counts 0..PRESCALE-1 only while in RUN and is cleared in IDLE and LOAD; tick pulses 1 cycle when count==PRESCALE-1.
REQ-017 LOAD copies table[step_idx] into the active duty_r/g/b and dur registers and clears tick_cnt.
REQ-018 Each step lasts dur+1 ticks (1..16), ending on the tick that makes tick_cnt==dur.
REQ-019 Step end, step_idx<STEPS-1: step_idx increments and the FSM goes to LOAD.
REQ-020 Step end, step_idx==STEPS-1, loop_en=1: step_idx wraps to 0 and the FSM goes to LOAD.
REQ-021 Step end, step_idx==STEPS-1, loop_en=0: the FSM goes to IDLE, done pulses in the same cycle as the transition, and step_idx returns to 0.
REQ-022 PWM: an 8-bit free-running counter increments every clk while busy; pwm_x = (pwm_cnt < duty_x), registered, so duty 0 is always off, 255 gives 255/256 on, and period is 256 clk.
REQ-023 In IDLE: pwm_r/g/b = 0, pwm_cnt = 0, duty registers = 0.
REQ-024 stop has priority over start and over a step end in the same cycle; outputs are 0 from the next cycle, and done does not pulse.
REQ-025 start while busy is ignored.
REQ-026 Table writes are accepted in every state; a write to the entry being loaded in the same cycle loads the old data (read-before-write), and the new data applies at that entry's next LOAD.
REQ-027 Table contents are not cleared by reset, and the table is undefined until written.
REQ-028 loop_en is sampled only at the last step's end.

Reset
REQ-029 With rst_n=0 at a clk edge: state=IDLE, busy=0, done=0, step_idx=0, pwm_r/g/b=0, prescaler=0, tick_cnt=0, pwm_cnt=0, duty registers=0.
REQ-030 Reset mid-sequence behaves as REQ-029 on the next edge, with no done pulse.

Structure
REQ-031 Package led_seq_pkg holds the state enum, the cfg_data field offsets, DUTY_W=8, and DUR_W=4.
REQ-032 The table is a STEPS x 28 register array with a synchronous write port and an asynchronous read port, inferable as LUT RAM.
REQ-033 One sub-module, led_pwm_ch (duty in, shared pwm_cnt in, registered pwm out), is instantiated three times.

Verification (PRESCALE=4, STEPS=8)
REQ-034 Load entry 0 = {dur 1, r 8'h80, g 0, b 8'hFF}, entry 7 = dur 0; pulse start with loop_en=0. Required: busy rises 1 cycle later; pwm_r is high 128/256 and pwm_b 255/256 per period; step 0 lasts 8 RUN cycles; done pulses once after step 7.
REQ-035 Same setup with loop_en=1. Required: step_idx sequences 0..7,0,1; done never pulses.
REQ-036 Assert stop and a step-end tick in the same cycle. Required: state goes to IDLE; all pwm outputs are 0 next cycle; done stays 0.
REQ-037 Write entry 3 in the same cycle as its LOAD. Required: the old duty is used; on the second loop pass the new duty is used.
REQ-038 Assert rst_n=0 mid-RUN at step 5. Required: on the next edge busy=0, step_idx=0, all outputs 0; a subsequent start begins at step 0 with table contents intact.
REQ-039 Set duty 0 and duty 255 on separate steps. Required: pwm is constant 0, and low exactly 1 cycle per 256, respectively.
